combo_lock_fsm: RTL
===================

Name: combo_lock_fsm

Overview:
- Downstream consumer of the 8-bit ALU stage: each press of ENTER samples the ALU result R and condition codes CC as one "digit" of a combination.
- Tracks a three-digit sequence, opens on a full match, counts failed attempts and enforces a timed lockout.
- Drives the lock status LEDs and a state code for the HEX display logic on the DE10-Lite.

Parameters:
- CODE0, 8'h2A, first digit to match against R.
- CODE1, 8'h07, second digit.
- CODE2, 8'hC3, third digit.
- CC_MASK, 6'b000000, CC bits that must also match on every digit; 0 means CC is ignored.
- CC_VAL, 6'b000000, required CC value under CC_MASK; CC order is {V+, V-, C, B, Z, N}.
- MAX_TRIES, 3, failed attempts that trigger lockout; legal range 1..7.
- LOCKOUT_CYCLES, 50_000_000, lockout duration in clk cycles (1 s at 50 MHz); must be at least 1.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- enter  in  1  single-cycle pulse, already debounced and edge-detected upstream.
- R  in  8  ALU result.
- CC  in  6  ALU condition codes {V+, V-, C, B, Z, N}.
- unlocked  out  1  high while in OPEN.
- locked_out  out  1  high while in LOCKOUT.
- err  out  1  one-cycle pulse on each failed attempt.
- progress  out  2  number of correct digits accepted so far in the current attempt (0..2).
- fail_count  out  3  failed attempts since the last successful open or lockout expiry.
- state_code  out  3  S0=0, S1=1, S2=2, OPEN=3, LOCKOUT=4.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state=S0. unlocked=0, locked_out=0, err=0, progress=0, fail_count=0, timer=0. Reset overrides everything, including mid-lockout and OPEN.
- All outputs are registered. The response to an enter sampled at edge k is visible after edge k; state, outputs and counters change on that same edge. The ALU is combinational, so R and CC are valid in the cycle enter is high.
- Digit match: R==CODEn AND (CC & CC_MASK)==(CC_VAL & CC_MASK).
- S0: enter+match -> S1, progress=1. enter+mismatch -> FAIL action.
- S1: enter+match(CODE1) -> S2, progress=2. mismatch -> FAIL.
- S2: enter+match(CODE2) -> OPEN; unlocked=1, progress=0, fail_count=0. mismatch -> FAIL.
- FAIL action, applied in the same edge:
  - err=1 for exactly one cycle; progress=0.
  - If fail_count+1 == MAX_TRIES: -> LOCKOUT, locked_out=1, timer=LOCKOUT_CYCLES-1, fail_count=MAX_TRIES.
  - Else: fail_count+=1 and -> S0.
- OPEN: enter (R and CC ignored) -> S0, unlocked=0 (relock). No timeout.
- LOCKOUT:
  - enter is ignored: no err, no counter change.
  - timer decrements each cycle.
  - On the edge where timer==0: -> S0, locked_out=0, fail_count=0.
  - Total lockout is exactly LOCKOUT_CYCLES cycles.
- No enter: state holds, except the LOCKOUT timer.
- err defaults to 0 every cycle unless a FAIL action occurs.
- Timer width: $clog2(LOCKOUT_CYCLES)+1 bits, unsigned. Timer is used only in LOCKOUT and never wraps.
- fail_count saturates at MAX_TRIES and never exceeds it.

Test Plan:
- Reset then enter with R=2A, 07, C3 on three separate pulses -> progress 1,2 then unlocked=1, state_code=3, fail_count=0, err never high.
- From OPEN, one enter (R=00) -> unlocked=0, state_code=0 on the next cycle; a second correct sequence reopens.
- Enter R=2A, then R=08 -> err high for one cycle, progress=0, fail_count=1, state_code=0. The following correct sequence opens and clears fail_count to 0.
- MAX_TRIES=3, LOCKOUT_CYCLES=8: three wrong first digits (R=00) -> third err coincides with locked_out=1 and state_code=4. Enter pulses during lockout give no err and no change. locked_out falls exactly 8 cycles after entry; fail_count=0.
- CC_MASK=6'b000010, CC_VAL=6'b000010: R=2A with CC=000000 -> err. R=2A with CC=000010 -> progress=1.
- Assert reset in S2 and again mid-lockout -> all outputs return to their reset values after the reset edge; the next enter is evaluated from S0.

Source files
------------

// File: rtl/combo_lock_fsm.sv
// Three-digit combination lock fed by the ALU result and condition codes.
// Counts failed attempts and holds a timed lockout after MAX_TRIES failures.
module combo_lock_fsm #(
   parameter logic [7:0] CODE0          = 8'h2A,
   parameter logic [7:0] CODE1          = 8'h07,
   parameter logic [7:0] CODE2          = 8'hC3,
   parameter logic [5:0] CC_MASK        = 6'b000000,
   parameter logic [5:0] CC_VAL         = 6'b000000,
   parameter int         MAX_TRIES      = 3,
   parameter int         LOCKOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enter,
   input  logic [7:0] R,
   input  logic [5:0] CC,
   output logic       unlocked,
   output logic       locked_out,
   output logic       err,
   output logic [1:0] progress,
   output logic [2:0] fail_count,
   output logic [2:0] state_code
);

   localparam int            TW        = $clog2(LOCKOUT_CYCLES) + 1;
   localparam logic [TW-1:0] LOCK_INIT = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [2:0]    MAX_FC    = 3'(MAX_TRIES);
   localparam logic [3:0]    MAX_FC4   = 4'(MAX_TRIES);

   typedef enum logic [2:0] {
      S0      = 3'd0,
      S1      = 3'd1,
      S2      = 3'd2,
      OPEN    = 3'd3,
      LOCKOUT = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    fc_d;
   logic [1:0]    prog_d;
   logic          unl_d, lo_d, err_d;
   logic          fail_now;
   logic [7:0]    exp_code;

   function automatic logic digit_ok(input logic [7:0] r, input logic [5:0] cc,
                                     input logic [7:0] code);
      return (r == code) && ((cc & CC_MASK) == (CC_VAL & CC_MASK));
   endfunction

   function automatic logic [2:0] sat_inc(input logic [2:0] fc);
      if (fc >= MAX_FC) return MAX_FC;
      return fc + 3'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S0;
         timer_q    <= '0;
         fail_count <= '0;
         progress   <= '0;
         unlocked   <= 1'b0;
         locked_out <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         fail_count <= fc_d;
         progress   <= prog_d;
         unlocked   <= unl_d;
         locked_out <= lo_d;
         err        <= err_d;
      end
   end

   assign state_code = state_q;

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      fc_d     = fail_count;
      prog_d   = progress;
      unl_d    = unlocked;
      lo_d     = locked_out;
      err_d    = 1'b0;
      fail_now = 1'b0;
      exp_code = CODE0;

      case (state_q)
         S0, S1, S2: begin
            if (state_q == S1)      exp_code = CODE1;
            else if (state_q == S2) exp_code = CODE2;
            if (enter) begin
               if (digit_ok(R, CC, exp_code)) begin
                  case (state_q)
                     S0: begin
                        state_d = S1;
                        prog_d  = 2'd1;
                     end
                     S1: begin
                        state_d = S2;
                        prog_d  = 2'd2;
                     end
                     default: begin
                        state_d = OPEN;
                        prog_d  = 2'd0;
                        unl_d   = 1'b1;
                        fc_d    = 3'd0;
                     end
                  endcase
               end else begin
                  fail_now = 1'b1;
               end
            end
         end
         OPEN: begin
            if (enter) begin
               state_d = S0;
               unl_d   = 1'b0;
            end
         end
         LOCKOUT: begin
            // enter is deliberately not looked at here
            if (timer_q == '0) begin
               state_d = S0;
               lo_d    = 1'b0;
               fc_d    = 3'd0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: state_d = S0;
      endcase

      if (fail_now) begin
         err_d  = 1'b1;
         prog_d = 2'd0;
         if (({1'b0, fail_count} + 4'd1) == MAX_FC4) begin
            state_d = LOCKOUT;
            lo_d    = 1'b1;
            timer_d = LOCK_INIT;
            fc_d    = MAX_FC;
         end else begin
            state_d = S0;
            fc_d    = sat_inc(fail_count);
         end
      end
   end

endmodule
